// File: rtl/cpu_wishbone_master_if_if.sv
// Wishbone classic bus bundle between the CPU-side initiator and the
// interconnect. Signal suffixes are named from the initiator's point of view.
interface cpu_wishbone_master_if_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic                  wishbone_cyc_o;
  logic                  wishbone_stb_o;
  logic                  wishbone_we_o;
  logic [ADDR_WIDTH-1:0] wishbone_addr_o;
  logic [DATA_WIDTH-1:0] wishbone_data_o;
  logic [SEL_WIDTH-1:0]  wishbone_sel_o;
  logic [DATA_WIDTH-1:0] wishbone_data_i;
  logic                  wishbone_ack_i;

  modport master (
    output wishbone_cyc_o, wishbone_stb_o, wishbone_we_o,
    output wishbone_addr_o, wishbone_data_o, wishbone_sel_o,
    input  wishbone_data_i, wishbone_ack_i
  );

  modport slave (
    input  wishbone_cyc_o, wishbone_stb_o, wishbone_we_o,
    input  wishbone_addr_o, wishbone_data_o, wishbone_sel_o,
    output wishbone_data_i, wishbone_ack_i
  );
endinterface

// File: rtl/cpu_wishbone_master_if.sv
// Converts the pipeline's single-cycle RAM-style access port into registered
// Wishbone classic cycles, stalling the pipeline while a cycle is open.
//
// Handshake: the pipeline holds cpu_ce_i (and address/data/sel) until it sees
// stallreq_o low; a cycle on the bus runs while cyc=stb=1 and completes in the
// cycle the slave raises ack. flush_i aborts, and an optional watchdog aborts
// after TIMEOUT cycles without ack (reported by a one-cycle err_o pulse).
module cpu_wishbone_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int TIMEOUT    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_ce_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  input  logic [SEL_WIDTH-1:0]  cpu_sel_i,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  stallreq_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  output logic                  err_o,
  output logic [1:0]            state_dbg_o,
  cpu_wishbone_master_if_if.master wb
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam bit          WDOG_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WDOG_LAST = WDOG_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t                state_q, state_d;
  logic                  cyc_q, cyc_d;   // drives both cyc and stb
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;   // read data held while the pipe is stalled
  logic [15:0]           cnt_q, cnt_d;   // watchdog cycle counter
  logic                  err_q, err_d;

  // Next-state, next-register and combinational pipeline outputs.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    stallreq_o = 1'b0;
    cpu_data_o = '0;

    unique case (state_q)
      IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          cyc_d   = 1'b1;
          we_d    = cpu_we_i;
          addr_d  = cpu_addr_i;
          data_d  = cpu_data_i;
          sel_d   = cpu_sel_i;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (wb.wishbone_ack_i) begin
          // Ack outranks a simultaneous flush: the access did complete.
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          addr_d     = '0;
          data_d     = '0;
          sel_d      = '0;
          buf_d      = we_q ? '0 : wb.wishbone_data_i;
          cpu_data_o = we_q ? '0 : wb.wishbone_data_i;
          state_d    = stall_i ? WAIT_STALL : IDLE;
        end else if (flush_i) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          sel_d   = '0;
          buf_d   = '0;
          state_d = IDLE;
        end else if (WDOG_EN && (cnt_q == WDOG_LAST)) begin
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          sel_d   = '0;
          buf_d   = '0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
          stallreq_o = 1'b1;
        end
      end

      WAIT_STALL: begin
        cpu_data_o = buf_q;
        if (!stall_i || flush_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bus registers with synchronous reset; an open cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign wb.wishbone_cyc_o  = cyc_q;
  assign wb.wishbone_stb_o  = cyc_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign err_o              = err_q;
  assign state_dbg_o        = state_q;

endmodule

// File: tb/tb_cpu_wishbone_master_if.sv
// Directed bench for cpu_wishbone_master_if: a programmable-wait-state slave,
// a read-data scoreboard and a linear sequence of access scenarios.
module tb_cpu_wishbone_master_if;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT hookup ----------------
  logic        cpu_ce = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        err;
  logic [1:0]  state_dbg;

  cpu_wishbone_master_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4)) wb ();

  cpu_wishbone_master_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce),
    .cpu_we_i   (cpu_we),
    .cpu_addr_i (cpu_addr),
    .cpu_data_i (cpu_wdata),
    .cpu_sel_i  (cpu_sel),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq),
    .stall_i    (stall),
    .flush_i    (flush),
    .err_o      (err),
    .state_dbg_o(state_dbg),
    .wb         (wb)
  );

  // ---------------- slave model ----------------
  logic        slave_on = 1'b0;
  int          wait_states = 0;
  int          ws_cnt = 0;
  logic [31:0] slave_rdata = '0;
  logic        ack;

  assign ack = slave_on && wb.wishbone_cyc_o && wb.wishbone_stb_o && (ws_cnt == wait_states);
  assign wb.wishbone_ack_i  = ack;
  assign wb.wishbone_data_i = slave_rdata;

  always @(posedge clk) begin
    if (!wb.wishbone_cyc_o || ack) ws_cnt <= 0;
    else                           ws_cnt <= ws_cnt + 1;
  end

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every completing read is matched against the oldest expected read value.
  always @(negedge clk) begin
    if (!rst && wb.wishbone_cyc_o && ack && !wb.wishbone_we_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_underflow: observed read %h expected none", cpu_data_o);
      end else begin
        chk("sb_rdata", cpu_data_o, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_cyc"},   {31'b0, wb.wishbone_cyc_o}, 32'd0);
    chk({tag, "_stb"},   {31'b0, wb.wishbone_stb_o}, 32'd0);
    chk({tag, "_we"},    {31'b0, wb.wishbone_we_o}, 32'd0);
    chk({tag, "_addr"},  wb.wishbone_addr_o, 32'd0);
    chk({tag, "_data"},  wb.wishbone_data_o, 32'd0);
    chk({tag, "_sel"},   {28'b0, wb.wishbone_sel_o}, 32'd0);
    chk({tag, "_state"}, {30'b0, state_dbg}, {30'b0, S_IDLE});
  endtask

  // One complete access against a slave with ws wait states, stall/flush low.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] sel, input logic [31:0] rdata, input int ws,
                        input string tag);
    int cyc_n;
    int stl_n;
    bit done;
    step();
    slave_rdata = rdata;
    wait_states = ws;
    slave_on    = 1'b1;
    cpu_ce      = 1'b1;
    cpu_we      = we;
    cpu_addr    = addr;
    cpu_wdata   = data;
    cpu_sel     = sel;
    if (!we) exp_q.push_back(rdata);
    cyc_n = 0;
    stl_n = 0;
    done  = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (stallreq) stl_n++;
      if (wb.wishbone_cyc_o) begin
        cyc_n++;
        chk({tag, "_stb_eq_cyc"}, {31'b0, wb.wishbone_stb_o}, 32'd1);
        chk({tag, "_we_o"},   {31'b0, wb.wishbone_we_o}, {31'b0, we});
        chk({tag, "_addr_o"}, wb.wishbone_addr_o, addr);
        chk({tag, "_data_o"}, wb.wishbone_data_o, data);
        chk({tag, "_sel_o"},  {28'b0, wb.wishbone_sel_o}, {28'b0, sel});
        if (ack) begin
          done = 1'b1;
          chk({tag, "_ack_stallreq"}, {31'b0, stallreq}, 32'd0);
          if (we) chk({tag, "_wr_cpu_data"}, cpu_data_o, 32'd0);
        end
      end
      step();
    end
    cpu_ce = 1'b0;
    chk({tag, "_done"},    {31'b0, done}, 32'd1);
    chk({tag, "_cyc_len"}, cyc_n, ws + 1);
    chk({tag, "_stl_len"}, stl_n, ws + 1);
    @(negedge clk);
    chk_bus_idle({tag, "_after"});
    chk({tag, "_after_stallreq"}, {31'b0, stallreq}, 32'd0);
    chk({tag, "_after_cpu_data"}, cpu_data_o, 32'd0);
  endtask

  // ---------------- global time limit ----------------
  initial begin
    #200000;
    $display("FAIL time_limit: observed no finish expected finish within 200000");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc_n;
    int stl_n;
    int err_n;
    int last_cyc;
    int err_i;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_bus_idle("rst");
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_stallreq", {31'b0, stallreq}, 32'd0);
    chk("rst_cpu_data", cpu_data_o, 32'd0);
    step();
    rst = 1'b0;

    // zero-wait read
    access(1'b0, 32'h0000_0100, 32'h0, 4'hF, 32'hDEAD_BEEF, 0, "rd0");
    // write with 3 wait states
    access(1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 32'hFFFF_FFFF, 3, "wr3");
    // a few more mixed accesses
    for (int k = 0; k < 3; k++) begin
      access(k[0], $urandom, $urandom, 4'($urandom_range(1, 15)), $urandom,
             $urandom_range(0, 4), "mix");
    end

    // read ack while the pipeline is stalled
    step();
    slave_rdata = 32'hA5A5_0001;
    wait_states = 0;
    slave_on    = 1'b1;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300; cpu_wdata = '0; cpu_sel = 4'hF;
    stall  = 1'b1;
    exp_q.push_back(32'hA5A5_0001);
    step();
    @(negedge clk);
    chk("ws_ack_cyc", {31'b0, wb.wishbone_cyc_o & ack}, 32'd1);
    chk("ws_ack_stallreq", {31'b0, stallreq}, 32'd0);
    step();
    cpu_ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("ws_state", {30'b0, state_dbg}, {30'b0, S_WAIT});
      chk("ws_hold", cpu_data_o, 32'hA5A5_0001);
      chk("ws_stallreq", {31'b0, stallreq}, 32'd0);
      chk("ws_cyc", {31'b0, wb.wishbone_cyc_o}, 32'd0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("ws_last_hold", cpu_data_o, 32'hA5A5_0001);
    step();
    @(negedge clk);
    chk("ws_exit_state", {30'b0, state_dbg}, {30'b0, S_IDLE});
    chk("ws_exit_cpu_data", cpu_data_o, 32'd0);

    // flush in the second BUSY cycle
    step();
    wait_states = 5;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0400; cpu_sel = 4'hF;
    step();
    @(negedge clk);
    chk("fl_busy1_cyc", {31'b0, wb.wishbone_cyc_o}, 32'd1);
    chk("fl_busy1_stallreq", {31'b0, stallreq}, 32'd1);
    step();
    flush  = 1'b1;
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("fl_busy2_state", {30'b0, state_dbg}, {30'b0, S_BUSY});
    chk("fl_stallreq", {31'b0, stallreq}, 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk_bus_idle("fl_after");
    chk("fl_after_cpu_data", cpu_data_o, 32'd0);

    // ack and flush in the same cycle: ack wins
    step();
    wait_states = 1;
    slave_rdata = 32'h0BAD_F00D;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500; cpu_sel = 4'hF;
    exp_q.push_back(32'h0BAD_F00D);
    step();
    step();
    flush  = 1'b1;
    cpu_ce = 1'b0;
    @(negedge clk);
    chk("af_ack", {31'b0, ack}, 32'd1);
    chk("af_cpu_data", cpu_data_o, 32'h0BAD_F00D);
    chk("af_stallreq", {31'b0, stallreq}, 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk_bus_idle("af_after");

    // watchdog: slave never acks
    step();
    slave_on = 1'b0;
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0600; cpu_sel = 4'hF;
    step();
    cpu_ce = 1'b0;
    cyc_n = 0; stl_n = 0; err_n = 0; last_cyc = -1; err_i = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wb.wishbone_cyc_o) begin
        cyc_n++;
        last_cyc = i;
        if (stallreq) stl_n++;
      end
      if (err) begin
        err_n++;
        err_i = i;
      end
      step();
    end
    chk("wd_cyc_len", cyc_n, 32'd8);
    chk("wd_stallreq_len", stl_n, 32'd7);
    chk("wd_err_count", err_n, 32'd1);
    chk("wd_err_when", err_i, last_cyc + 1);
    @(negedge clk);
    chk_bus_idle("wd_after");

    // reset asserted mid-BUSY
    step();
    slave_on = 1'b0;
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0700; cpu_wdata = 32'hCAFE_0007; cpu_sel = 4'hC;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rb_still_busy", {30'b0, state_dbg}, {30'b0, S_BUSY});
    step();
    @(negedge clk);
    chk_bus_idle("rb");
    chk("rb_err", {31'b0, err}, 32'd0);
    chk("rb_stallreq", {31'b0, stallreq}, 32'd1);
    step();
    rst    = 1'b0;
    cpu_ce = 1'b0;
    @(negedge clk);
    chk_bus_idle("rb_after");

    chk("sb_leftover", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_wishbone_master_if.md
# cpu_wishbone_master_if

Wishbone initiator that converts the CPU's single-cycle RAM-style port (instruction or data side) into registered Wishbone classic cycles. It sits between the OpenMIPS pipeline and the Wishbone interconnect, facing the RAM-side slave bridges. It asserts a pipeline stall request while a transaction is outstanding and holds read data while the pipeline itself is stalled. A flush aborts the cycle, and an optional watchdog aborts hung cycles.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- SEL_WIDTH, 4, byte-select width
- TIMEOUT, 0, maximum cycles to wait for ack in BUSY; 0 disables the watchdog; must be less than 65536

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_ce_i  in  1  CPU access request
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_addr_i  in  ADDR_WIDTH  access address
- cpu_data_i  in  DATA_WIDTH  write data
- cpu_sel_i  in  SEL_WIDTH  byte selects
- cpu_data_o  out  DATA_WIDTH  read data to the pipeline (combinational)
- stallreq_o  out  1  stall request to the pipeline controller (combinational)
- stall_i  in  1  pipeline stage is stalled by another source
- flush_i  in  1  pipeline flush; abort the current access
- err_o  out  1  one-cycle pulse when the watchdog aborts a cycle (registered)
- wishbone_cyc_o, wishbone_stb_o, wishbone_we_o  out  1 each  Wishbone controls (registered)
- wishbone_addr_o  out  ADDR_WIDTH  registered address
- wishbone_data_o  out  DATA_WIDTH  registered write data
- wishbone_sel_o  out  SEL_WIDTH  registered byte selects
- wishbone_data_i  in  DATA_WIDTH  slave read data
- wishbone_ack_i  in  1  slave acknowledge

## Operation
- Reset values:
  - state = IDLE.
  - All wishbone_*_o = 0.
  - err_o = 0, read buffer = 0, watchdog counter = 0.
- States: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: register cyc=stb=1 and we/addr/data/sel from the CPU inputs; clear the counter; go to BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i.
  - cpu_data_o = 0.
- BUSY, priority ack > flush > timeout:
  - ack_i=1: deassert cyc/stb/we and zero addr/data/sel.
    - Read: capture wishbone_data_i into the buffer. Write: capture 0.
    - Next state: WAIT_STALL if stall_i=1, else IDLE.
    - Same cycle: stallreq_o=0; cpu_data_o = wishbone_data_i for a read, 0 for a write.
  - flush_i=1 (no ack): drop all Wishbone outputs to 0, buffer = 0, go to IDLE; stallreq_o=0.
  - TIMEOUT≠0 and counter = TIMEOUT-1 (no ack, no flush): drop all outputs, buffer = 0, err_o=1 next cycle, go to IDLE; stallreq_o=0 in that cycle.
  - Otherwise: counter increments (saturating, 16 bits); stallreq_o=1; cpu_data_o=0.
- WAIT_STALL:
  - cpu_data_o = buffer; stallreq_o = 0.
  - stall_i=0 or flush_i=1 -> IDLE.
- Address/data are not re-sampled while BUSY; CPU input changes during BUSY are ignored.
- cyc_o and stb_o are always equal; there are no bursts and no back-to-back cycles without returning through IDLE.

## Timing
- Zero-wait slave (ack combinational on cyc&stb):
  - Request seen in IDLE at cycle N; cyc/stb high in cycle N+1; ack and read data also in N+1.
  - stallreq_o is high in cycle N only, so the pipeline loses 1 cycle.
- Slave with k wait states: cyc held high for k+1 cycles; stallreq_o high for k+1 cycles.
- cyc returns low the cycle after ack, so a new request cannot issue Wishbone until that cycle. The minimum spacing between accesses is 2 cycles.
- err_o is high for exactly 1 cycle, in the cycle after the timeout abort.
- A reset in any state returns all outputs to their reset values on the next edge; an outstanding cycle is dropped without waiting for ack.

## Test plan
- Read with zero-wait slave: addr 0x0000_0100 with slave data 0xDEAD_BEEF -> cyc high for 1 cycle; cpu_data_o=0xDEAD_BEEF in the ack cycle; stallreq_o high for 1 cycle.
- Write, 3 wait states: data 0x1234_5678, sel 4'b0011 -> cyc=stb=we=1 for 4 cycles with stable addr/data/sel; stallreq_o high for 4 cycles; all outputs 0 after ack.
- Read ack arriving while stall_i=1 for 2 more cycles: slave data 0xA5A5_0001 -> state WAIT_STALL; cpu_data_o holds 0xA5A5_0001 with stallreq_o=0 until stall_i falls, then IDLE with cpu_data_o=0.
- Flush during wait states: flush_i pulsed in the 2nd BUSY cycle -> cyc low on the next edge, stallreq_o=0, state IDLE. Ack and flush in the same cycle -> ack wins and data is returned.
- Watchdog with TIMEOUT=8 and a slave that never acks -> cyc high for exactly 8 cycles, err_o pulses once, state IDLE.
- Reset asserted mid-BUSY -> next edge: all wishbone_*_o=0, err_o=0, stallreq_o follows the IDLE rule.
